// File: rtl/xout_fifo_if.sv
// Handshake/status bundle between the add/sub result stage, xout_fifo and its consumer.
// PEAK exists only when XOUT_FIFO_PEAK_EN is defined.
interface xout_fifo_if #(
  parameter int unsigned NBITS      = 8,
  parameter int unsigned DEPTH_LOG2 = 3
);
  logic                  IN_VALID;
  logic [NBITS-1:0]      IN_DATA;
  logic                  OUT_VALID;
  logic                  OUT_READY;
  logic [NBITS-1:0]      OUT_DATA;
  logic [DEPTH_LOG2:0]   COUNT;
  logic                  FULL;
  logic                  EMPTY;
  logic                  OVF;
  logic                  CLR_STAT;
`ifdef XOUT_FIFO_PEAK_EN
  logic [NBITS-1:0]      PEAK;
`endif

  // FIFO side
  modport slave (
    input  IN_VALID, IN_DATA, OUT_READY, CLR_STAT,
    output OUT_VALID, OUT_DATA, COUNT, FULL, EMPTY, OVF
`ifdef XOUT_FIFO_PEAK_EN
    , output PEAK
`endif
  );

  // Producer/consumer side
  modport master (
    output IN_VALID, IN_DATA, OUT_READY, CLR_STAT,
    input  OUT_VALID, OUT_DATA, COUNT, FULL, EMPTY, OVF
`ifdef XOUT_FIFO_PEAK_EN
    , input PEAK
`endif
  );
endinterface

// File: rtl/xout_fifo.sv
// First-word-fall-through elastic buffer for XOUT results; drops and flags samples when full.
// Optional running-maximum register enabled by defining XOUT_FIFO_PEAK_EN.
module xout_fifo #(
  parameter int unsigned NBITS      = 8,
  parameter int unsigned DEPTH_LOG2 = 3
) (
  input  logic       CLK,
  input  logic       RST_N,
  xout_fifo_if.slave bus
);
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CW    = DEPTH_LOG2 + 1;

  logic [NBITS-1:0]      mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  ovf_q, ovf_d;

  logic full_c, empty_c, pop_c, push_c, drop_c;

  // Status is derived only from registered count
  assign full_c  = (count_q == CW'(DEPTH));
  assign empty_c = (count_q == CW'(0));
  // A same-cycle pop frees the head slot, so a full buffer can still accept
  assign pop_c   = !empty_c && bus.OUT_READY;
  assign push_c  = bus.IN_VALID && (!full_c || pop_c);
  assign drop_c  = bus.IN_VALID && full_c && !pop_c;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_c) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (pop_c)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    if (push_c && !pop_c)      count_d = count_q + CW'(1);
    else if (pop_c && !push_c) count_d = count_q - CW'(1);
    if (drop_c)       ovf_d = 1'b1;
    if (bus.CLR_STAT) ovf_d = 1'b0;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage array is intentionally not reset
  always_ff @(posedge CLK) begin
    if (push_c) mem_q[wr_ptr_q] <= bus.IN_DATA;
  end

`ifdef XOUT_FIFO_PEAK_EN
  logic [NBITS-1:0] peak_q, peak_d;

  always_comb begin
    peak_d = peak_q;
    if (bus.CLR_STAT)                              peak_d = push_c ? bus.IN_DATA : '0;
    else if (push_c && (bus.IN_DATA > peak_q))     peak_d = bus.IN_DATA;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) peak_q <= '0;
    else        peak_q <= peak_d;
  end

  assign bus.PEAK = peak_q;
`endif

  assign bus.OUT_VALID = !empty_c;
  assign bus.OUT_DATA  = mem_q[rd_ptr_q];
  assign bus.COUNT     = count_q;
  assign bus.FULL      = full_c;
  assign bus.EMPTY     = empty_c;
  assign bus.OVF       = ovf_q;
endmodule

// File: doc/xout_fifo.md
# xout_fifo

Elastic buffer directly downstream of the registered add/sub compare stage. It captures each 8-bit `XOUT` result on a per-cycle strobe and presents the results to the consumer over a valid/ready handshake in first-word-fall-through order. The add/sub stage has no backpressure input, so results arriving while the buffer is full are dropped and flagged.

## Interface
Parameters:
- `NBITS`, 8: data width; matches the upstream `XOUT` width.
- `DEPTH_LOG2`, 3: log2 of the entry count. DEPTH = 2**DEPTH_LOG2, so the default is 8 entries. Legal range is 1..8.

Ports:
- `CLK`  in  1  clock; all state updates on posedge.
- `RST_N`  in  1  asynchronous, active-low reset.
- `IN_VALID`  in  1  upstream result strobe, one sample per cycle when high.
- `IN_DATA`  in  NBITS  upstream result; sampled when `IN_VALID`=1.
- `OUT_VALID`  out  1  head entry available.
- `OUT_READY`  in  1  consumer accepts the head entry.
- `OUT_DATA`  out  NBITS  head entry; holds its value while `OUT_VALID` && !`OUT_READY`.
- `COUNT`  out  DEPTH_LOG2+1  number of stored entries.
- `FULL`  out  1  `COUNT`==DEPTH.
- `EMPTY`  out  1  `COUNT`==0.
- `OVF`  out  1  sticky flag: at least one sample has been dropped.
- `CLR_STAT`  in  1  synchronous clear of `OVF` (and of `PEAK` when configured).
- `PEAK`  out  NBITS  only present with `XOUT_FIFO_PEAK_EN`.

## Operation
- Storage: DEPTH×NBITS register array, a write pointer and a read pointer of DEPTH_LOG2 bits each, and a `COUNT` register.
- Pointers wrap modulo DEPTH.
- Pop = `OUT_VALID` && `OUT_READY`. The read pointer advances by 1 on a pop.
- Push = `IN_VALID` && (!`FULL` || pop). On a push, `IN_DATA` is written at the write pointer and the write pointer advances by 1.
- Drop = `IN_VALID` && `FULL` && !pop. On a drop, storage is unchanged and `OVF` is set to 1.
- `COUNT` update: push only → +1; pop only → −1; push and pop in the same cycle → unchanged.
- Push and pop together while full: the pop frees the slot, so the push is accepted; no drop, `COUNT` stays at DEPTH.
- Push and pop together while empty: impossible, because `OUT_VALID`=0. The push is accepted and `COUNT` becomes 1.
- `OUT_VALID` = !`EMPTY`. `OUT_DATA` = mem[rd_ptr], read combinationally from registered storage.
- `OUT_DATA` is don't-care when `OUT_VALID`=0.
- `OUT_READY` while empty has no effect.
- `CLR_STAT` has priority over a same-cycle set: `OVF` ends at 0 even if a drop occurs in that cycle.
- `CLR_STAT` does not touch the data, the pointers or `COUNT`.
- Reset values on `RST_N`=0, asynchronously:
  - pointers = 0, `COUNT`=0;
  - `EMPTY`=1, `FULL`=0, `OUT_VALID`=0;
  - `OVF`=0, `PEAK`=0;
  - `OUT_DATA` reads entry 0; the storage contents are not reset.
- Reset asserted mid-operation discards all stored entries immediately. The first cycle after release behaves as if the buffer were empty.

## Timing
- Write-to-read latency: a sample pushed at edge N is visible on `OUT_VALID`/`OUT_DATA` after edge N; the consumer can pop it at edge N+1.
- Sustained throughput: 1 push and 1 pop per cycle, with no bubbles at full or at empty.
- `FULL`, `EMPTY` and `COUNT` are registered, or derived only from registered state. No combinational path from `IN_VALID` to any output.
- Only combinational path: `OUT_READY` → push acceptance while full. It is internal only and does not appear on any output.
- `OVF` rises the edge after the first drop.

## Configuration
- Macro: `XOUT_FIFO_PEAK_EN`.
- Defined:
  - `PEAK` register holds the unsigned maximum over all pushed samples since reset or the last `CLR_STAT`.
  - It updates on the push edge: `PEAK` <= max(`PEAK`, `IN_DATA`).
  - `CLR_STAT` sets `PEAK` to 0. If a push occurs in the same cycle, `PEAK` is loaded with that `IN_DATA`.
  - Dropped samples do not update `PEAK`.
- Not defined: the `PEAK` port and its register are absent; all other behaviour is identical.

## Test plan
- Reset → `EMPTY`=1, `COUNT`=0, `OVF`=0, `OUT_VALID`=0. Push 0x05 → after the next edge, `OUT_VALID`=1, `OUT_DATA`=0x05, `COUNT`=1.
- Fill: push 0x10..0x17 with `OUT_READY`=0 → `FULL`=1, `COUNT`=8. Push 0x18 → dropped, `OVF`=1. Drain → data 0x10..0x17 in order, then `EMPTY`=1.
- Full with simultaneous push 0xAA and pop → no drop, `COUNT` stays 8, `OVF` stays 0. The last entry drained is 0xAA.
- Stream 20 samples with `OUT_READY`=1 every cycle → `COUNT` never exceeds 1, output order is preserved, wrap-around across entries 7→0 is correct.
- `RST_N` pulsed low with `COUNT`=5 → immediately `EMPTY`=1, `OUT_VALID`=0. A push of 0x33 after release is the next entry read.
- With `XOUT_FIFO_PEAK_EN`: push 0x20, 0xF0, 0x40 → `PEAK`=0xF0. `CLR_STAT` in the same cycle as a push of 0x07 → `PEAK`=0x07 and `OVF` cleared.
